// File: rtl/ac_seq_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : ac_seq_mul_sched
// Summary  : Sequencing controller that time-multiplexes one external 4x4
//            approximate sub-multiplier to build a 16-bit product of two
//            8-bit operands (partial products LL, LH, HL, HH, shift-accumulated).
// Options  : AC_SEQ_ZERO_SKIP_EN - skip partial products whose nibble pair
//            contains a zero nibble.
// Revision : 1.0 - initial release
// ============================================================================
module ac_seq_mul_sched #(
    parameter logic [1:0] MODE_LL = 2'd3,
    parameter logic [1:0] MODE_LH = 2'd3,
    parameter logic [1:0] MODE_HL = 2'd3,
    parameter logic [1:0] MODE_HH = 2'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_prod,
    output logic [3:0]  sm_a,
    output logic [3:0]  sm_b,
    output logic [1:0]  sm_mode,
    input  logic [7:0]  sm_prod,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PP_LL = 3'd1,
        PP_LH = 3'd2,
        PP_HL = 3'd3,
        PP_HH = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic        w_accept;
    logic        w_pp;
    logic [3:0]  w_shift;
    logic [3:0]  w_need;   // bit0 LL, bit1 LH, bit2 HL, bit3 HH

`ifdef AC_SEQ_ZERO_SKIP_EN
    logic [7:0] w_opa;
    logic [7:0] w_opb;

    // In IDLE the operands are not yet registered, so the first-PP decision
    // looks at the live inputs; afterwards it uses the captured operands.
    assign w_opa     = (r_state == IDLE) ? in_a : r_a;
    assign w_opb     = (r_state == IDLE) ? in_b : r_b;
    assign w_need[0] = (w_opa[3:0] != 4'd0) && (w_opb[3:0] != 4'd0);
    assign w_need[1] = (w_opa[3:0] != 4'd0) && (w_opb[7:4] != 4'd0);
    assign w_need[2] = (w_opa[7:4] != 4'd0) && (w_opb[3:0] != 4'd0);
    assign w_need[3] = (w_opa[7:4] != 4'd0) && (w_opb[7:4] != 4'd0);
`else
    assign w_need = 4'b1111;
`endif

    // First partial product at or after the allowed position that still
    // needs issuing; DONE when none remain.
    function automatic state_t pick_next(input logic [3:0] need, input logic [3:0] allow);
        logic [3:0] m;
        m = need & allow;
        if (m[0])      return PP_LL;
        else if (m[1]) return PP_LH;
        else if (m[2]) return PP_HL;
        else if (m[3]) return PP_HH;
        else           return DONE;
    endfunction

    assign w_accept = (r_state == IDLE) && in_valid;
    assign busy     = (r_state != IDLE);
    // The accumulator is only exposed while the result is being offered.
    assign out_prod = out_valid ? r_acc : 16'd0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and sub-multiplier drive, decoded from the registered state.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sm_a      = 4'd0;
        sm_b      = 4'd0;
        sm_mode   = 2'd0;
        w_shift   = 4'd0;
        w_pp      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = pick_next(w_need, 4'b1111);
            end
            PP_LL: begin
                sm_a    = r_a[3:0];
                sm_b    = r_b[3:0];
                sm_mode = MODE_LL;
                w_shift = 4'd0;
                w_pp    = 1'b1;
                w_next  = pick_next(w_need, 4'b1110);
            end
            PP_LH: begin
                sm_a    = r_a[3:0];
                sm_b    = r_b[7:4];
                sm_mode = MODE_LH;
                w_shift = 4'd4;
                w_pp    = 1'b1;
                w_next  = pick_next(w_need, 4'b1100);
            end
            PP_HL: begin
                sm_a    = r_a[7:4];
                sm_b    = r_b[3:0];
                sm_mode = MODE_HL;
                w_shift = 4'd4;
                w_pp    = 1'b1;
                w_next  = pick_next(w_need, 4'b1000);
            end
            PP_HH: begin
                sm_a    = r_a[7:4];
                sm_b    = r_b[7:4];
                sm_mode = MODE_HH;
                w_shift = 4'd8;
                w_pp    = 1'b1;
                w_next  = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture and modulo-2^16 shift-accumulate of each partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= 8'd0;
            r_b   <= 8'd0;
            r_acc <= 16'd0;
        end else if (w_accept) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_acc <= 16'd0;
        end else if (w_pp) begin
            r_acc <= r_acc + ({8'd0, sm_prod} << w_shift);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ac_seq_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ac_seq_mul_sched
// Summary  : Self-checking bench for ac_seq_mul_sched with an exact 4x4
//            sub-multiplier model and an expected-product scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ac_seq_mul_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic [3:0]  sm_a;
    logic [3:0]  sm_b;
    logic [1:0]  sm_mode;
    logic [7:0]  sm_prod;
    logic        busy;
    logic        force_ff;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [9:0]  cap_q[$];

    ac_seq_mul_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .sm_a      (sm_a),
        .sm_b      (sm_b),
        .sm_mode   (sm_mode),
        .sm_prod   (sm_prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Exact sub-multiplier, or a stuck 0xFF to exercise accumulator wrap.
    assign sm_prod = force_ff ? 8'hFF : ({4'd0, sm_a} * {4'd0, sm_b});

    // Record what is issued to the sub-multiplier in every PP cycle.
    always @(negedge clk) begin
        if (rst_n && busy && !in_ready && !out_valid)
            cap_q.push_back({sm_a, sm_b, sm_mode});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        cap_q.delete();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_op(input string tag, input int exp_lat);
        logic [15:0] e;
        wait_valid(tag, exp_lat);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_prod"}, {16'd0, out_prod}, {16'd0, e});
        end else begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_prod"},  {16'd0, out_prod},  32'd0);
        check({tag, "_sm"},        {22'd0, sm_a, sm_b, sm_mode}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
    endtask

    initial begin
        logic [9:0]  exp_seq [4];
        logic [15:0] e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        out_ready = 1'b0;
        force_ff  = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // out_ready with nothing pending has no effect.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_out_ready_valid", {31'd0, out_valid}, 32'd0);
        check("idle_out_ready_busy",  {31'd0, busy},      32'd0);

        // Full-scale operands.
        start_op(8'hFF, 8'hFF, 16'hFE01);
        finish_op("ff_ff", 5);
        check("ff_ff_pp_count", 32'(cap_q.size()), 32'd4);

        // Issue order and modes.
        start_op(8'h12, 8'h34, 16'h03A8);
        finish_op("x12_x34", 5);
        exp_seq[0] = {4'd2, 4'd4, 2'd3};
        exp_seq[1] = {4'd2, 4'd3, 2'd3};
        exp_seq[2] = {4'd1, 4'd4, 2'd3};
        exp_seq[3] = {4'd1, 4'd3, 2'd1};
        check("x12_x34_pp_count", 32'(cap_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_q.size())
                check($sformatf("x12_x34_issue%0d", i), {22'd0, cap_q[i]}, {22'd0, exp_seq[i]});
        end

        // Stuck sub-multiplier output forces a modulo-2^16 wrap.
        force_ff = 1'b1;
        start_op(8'h11, 8'h11, 16'h1FDF);
        finish_op("wrap", 5);
        force_ff = 1'b0;

        // Result held under back-pressure; new operands ignored meanwhile.
        start_op(8'h21, 8'h43, 16'h08A3);
        wait_valid("stall", 5);
        e = exp_q.pop_front();
        for (int i = 0; i < 7; i++) begin
            in_valid = (i % 2 == 0);
            in_a     = 8'hAA;
            in_b     = 8'h55;
            @(posedge clk); #1;
            check($sformatf("stall_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall_prod%0d", i),  {16'd0, out_prod},  {16'd0, e});
            check($sformatf("stall_ready%0d", i), {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall_release_valid", {31'd0, out_valid}, 32'd0);
        check("stall_release_idle",  {31'd0, in_ready},  32'd1);
        @(posedge clk); #1;
        check("stall_no_ghost_accept", {31'd0, busy}, 32'd0);

        // Asynchronous reset during PP_HL discards the operation.
        start_op(8'h12, 8'h34, 16'h03A8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_hold_valid%0d", i), {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        start_op(8'h35, 8'h27, 16'h0813);
        check("midrst_first_accept", {31'd0, busy}, 32'd1);
        finish_op("post_rst", 5);

`ifdef AC_SEQ_ZERO_SKIP_EN
        start_op(8'h0F, 8'h0F, 16'h00E1);
        finish_op("skip_ll_only", 2);
        check("skip_ll_only_pp_count", 32'(cap_q.size()), 32'd1);
        start_op(8'h00, 8'h5A, 16'h0000);
        finish_op("skip_all", 1);
        check("skip_all_pp_count", 32'(cap_q.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
